// File: rtl/seg_life_pkg.sv
// seg_life_pkg: shared types and constants for the seven-segment life automaton
package seg_life_pkg;
  localparam int CELLS = 7;
  localparam int TAP_HI = 6;
  localparam int TAP_LO = 5;
  localparam logic [CELLS-1:0] SEG_OFF = 7'h00;
  typedef enum logic [1:0] {LOAD, WAIT, STEP, CHECK} state_e;
endpackage

// File: rtl/seg_life_lfsr.sv
// seg_life_lfsr: 7-bit Fibonacci LFSR seed source
//   clk_i, reset_i  clock, async active-high reset (loads SEED)
//   adv_i           advance one state
//   lfsr_o          current pattern
module seg_life_lfsr
  import seg_life_pkg::*;
#(
  parameter logic [CELLS-1:0] SEED = 7'h5A
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             adv_i,
  output logic [CELLS-1:0] lfsr_o
);
  logic [CELLS-1:0] lfsr_q, lfsr_d;
  assign lfsr_d = adv_i ? {lfsr_q[CELLS-2:0], lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO]} : lfsr_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
  assign lfsr_o = lfsr_q;
endmodule

// File: rtl/seg_life_sequencer.sv
// seg_life_sequencer: paces, seeds and stall-checks the seven-segment life automaton
//   clk_i, reset_i                    clock, async active-high reset
//   run_i, rate_i                     free-run enable and WAIT length (rate+1)
//   step_req_i, reseed_req_i          edge-detected single-step / reseed requests
//   auto_en_i                         reseed automatically on stall or extinction
//   cells_i                           current automaton generation
//   step_en_o, load_en_o, load_data_o core strobes and seed pattern
//   stalled_o, gen_count_o            status
module seg_life_sequencer
  import seg_life_pkg::*;
#(
  parameter int               PRESCALE_W  = 4,
  parameter int               STALL_LIMIT = 3,
  parameter logic [CELLS-1:0] LFSR_SEED   = 7'h5A
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  run_i,
  input  logic                  step_req_i,
  input  logic                  reseed_req_i,
  input  logic                  auto_en_i,
  input  logic [PRESCALE_W-1:0] rate_i,
  input  logic [CELLS-1:0]      cells_i,
  output logic                  step_en_o,
  output logic                  load_en_o,
  output logic [CELLS-1:0]      load_data_o,
  output logic                  stalled_o,
  output logic [7:0]            gen_count_o
);
  localparam logic [2:0] LIM = 3'(STALL_LIMIT);
  state_e state_q, state_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [7:0] gen_q, gen_d;
  logic [2:0] stall_q, stall_d, stall_nxt;
  logic [CELLS-1:0] prev1_q, prev1_d, prev2_q, prev2_d, lfsr;
  logic stalled_q, stalled_d, stalled_nxt;
  logic p2v_q, p2v_d, step_lvl_q, reseed_lvl_q, step_edge, reseed_edge, rep;
  seg_life_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .adv_i  (state_q == LOAD),
    .lfsr_o (lfsr)
  );
  assign step_edge   = step_req_i & ~step_lvl_q;
  assign reseed_edge = reseed_req_i & ~reseed_lvl_q;
  // period-2 oscillation shows up as a match against the generation before last
  assign rep         = (cells_i == prev1_q) | (p2v_q & (cells_i == prev2_q));
  assign stall_nxt   = !rep ? 3'd0 : (stall_q == LIM) ? stall_q : stall_q + 3'd1;
  assign stalled_nxt = (cells_i == SEG_OFF) | (stall_nxt == LIM);
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    gen_d     = gen_q;
    stall_d   = stall_q;
    stalled_d = stalled_q;
    prev1_d   = prev1_q;
    prev2_d   = prev2_q;
    p2v_d     = p2v_q;
    unique case (state_q)
      LOAD: begin
        gen_d     = '0;
        stall_d   = '0;
        pre_d     = '0;
        stalled_d = 1'b0;
        prev1_d   = lfsr;
        p2v_d     = 1'b0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (reseed_edge) state_d = LOAD;
        else if (run_i) begin
          pre_d   = (pre_q == rate_i) ? '0 : pre_q + 1'b1;
          state_d = (pre_q == rate_i) ? STEP : WAIT;
        end else begin
          pre_d   = '0;
          state_d = step_edge ? STEP : WAIT;
        end
      end
      STEP: begin
        gen_d   = gen_q + 8'd1;
        state_d = CHECK;
      end
      CHECK: begin
        stall_d   = stall_nxt;
        stalled_d = stalled_nxt;
        prev2_d   = prev1_q;
        p2v_d     = 1'b1;
        prev1_d   = cells_i;
        state_d   = (auto_en_i & stalled_nxt) ? LOAD : WAIT;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q      <= LOAD;
      pre_q        <= '0;
      gen_q        <= '0;
      stall_q      <= '0;
      stalled_q    <= 1'b0;
      prev1_q      <= '0;
      prev2_q      <= '0;
      p2v_q        <= 1'b0;
      step_lvl_q   <= 1'b0;
      reseed_lvl_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      gen_q        <= gen_d;
      stall_q      <= stall_d;
      stalled_q    <= stalled_d;
      prev1_q      <= prev1_d;
      prev2_q      <= prev2_d;
      p2v_q        <= p2v_d;
      step_lvl_q   <= step_req_i;
      reseed_lvl_q <= reseed_req_i;
    end
  // strobes decode the state but are masked by reset so nothing pulses while held in reset
  assign load_en_o   = (state_q == LOAD) & ~reset_i;
  assign step_en_o   = (state_q == STEP) & ~reset_i;
  assign load_data_o = load_en_o ? lfsr : SEG_OFF;
  assign stalled_o   = stalled_q;
  assign gen_count_o = gen_q;
endmodule

// File: tb/tb_seg_life_sequencer.sv
// tb_seg_life_sequencer: randomized bench for seg_life_sequencer with a behavioural model
module tb_seg_life_sequencer;
  logic clk = 1'b0;
  logic reset, run, step_req, reseed_req, auto_en;
  logic [3:0] rate;
  logic [6:0] cells, load_data;
  logic step_en, load_en, stalled;
  logic [7:0] gen_count;
  int checks = 0, failures = 0, cyc = 0;
  bit tog = 0, rnd_cells = 0;
  localparam int P_LOAD = 0, P_WAIT = 1, P_STEP = 2, P_CHECK = 3;
  int ph, m_gen, m_rep;
  logic [3:0] m_pre;
  logic [6:0] m_lfsr;
  logic m_stalled, m_sprev, m_rprev;
  logic [6:0] hist[$];
  always #5 clk = ~clk;
  seg_life_sequencer dut (
    .clk_i(clk), .reset_i(reset), .run_i(run), .step_req_i(step_req),
    .reseed_req_i(reseed_req), .auto_en_i(auto_en), .rate_i(rate), .cells_i(cells),
    .step_en_o(step_en), .load_en_o(load_en), .load_data_o(load_data),
    .stalled_o(stalled), .gen_count_o(gen_count)
  );
  function automatic logic [6:0] lfsr_next(input logic [6:0] x);
    int v;
    v = int'(x);
    return 7'(((v * 2) % 128) + (((v / 64) + (v / 32)) % 2));
  endfunction
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic model_reset();
    ph = P_LOAD; m_pre = 0; m_lfsr = 7'h5A; m_gen = 0; m_rep = 0;
    m_stalled = 0; m_sprev = 0; m_rprev = 0; hist = {};
  endtask
  task automatic model_adv();
    if (reset) model_reset();
    else begin
      logic se, re, rp, st;
      se = step_req && !m_sprev;
      re = reseed_req && !m_rprev;
      if (ph == P_LOAD) begin
        hist = {m_lfsr};
        m_lfsr = lfsr_next(m_lfsr);
        m_gen = 0; m_rep = 0; m_pre = 0; m_stalled = 0; ph = P_WAIT;
      end else if (ph == P_WAIT) begin
        if (re) ph = P_LOAD;
        else if (run) begin
          if (m_pre == rate) begin m_pre = 0; ph = P_STEP; end
          else m_pre = m_pre + 4'd1;
        end else begin
          m_pre = 0;
          if (se) ph = P_STEP;
        end
      end else if (ph == P_STEP) begin
        m_gen = (m_gen + 1) % 256; ph = P_CHECK;
      end else begin
        rp = (cells == hist[hist.size()-1]) || (hist.size() > 1 && cells == hist[hist.size()-2]);
        m_rep = rp ? m_rep + 1 : 0;
        st = (cells == 7'h00) || (m_rep >= 3);
        m_stalled = st;
        hist.push_back(cells);
        if (hist.size() > 2) void'(hist.pop_front());
        ph = (auto_en && st) ? P_LOAD : P_WAIT;
      end
      m_sprev = step_req; m_rprev = reseed_req;
    end
  endtask
  task automatic cmp_all();
    logic el, es;
    el = !reset && ph == P_LOAD;
    es = !reset && ph == P_STEP;
    check("load_en", load_en, el);
    check("step_en", step_en, es);
    check("load_data", load_data, el ? m_lfsr : 7'h00);
    check("stalled", stalled, m_stalled);
    check("gen_count", gen_count, 8'(m_gen));
  endtask
  task automatic tick();
    @(negedge clk);
    cmp_all();
    @(posedge clk);
    #1;
    cyc++;
    model_adv();
    if (tog && step_en) cells = (cells == 7'h21) ? 7'h12 : 7'h21;
    if (rnd_cells) cells = 7'($urandom);
  endtask
  task automatic wait_step(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (step_en) begin at = cyc; break; end
    end
    if (at < 0) check("wait_step_timeout", 0, 1);
  endtask
  task automatic steps_to_load(output int n);
    bit found;
    n = 0; found = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (load_en) begin found = 1; break; end
      if (step_en) n++;
    end
    if (!found) check("wait_load_timeout", 0, 1);
  endtask
  task automatic reseed_pulse();
    for (int i = 0; i < 60 && !(ph == P_WAIT && !m_rprev); i++) tick();
    reseed_req = 1;
    tick();
    check("reseed_load_en", load_en, 1);
    reseed_req = 0;
  endtask
  initial begin
    int a, b, n, r;
    reset = 1; run = 0; step_req = 0; reseed_req = 0; auto_en = 0; rate = 0; cells = 0;
    model_reset();
    repeat (3) tick();
    check("rst_load_en", load_en, 0);
    check("rst_gen", gen_count, 0);
    reset = 0;
    #1;
    check("first_load_en", load_en, 1);
    check("first_seed", load_data, 8'h5A);
    reseed_pulse();
    check("second_seed", load_data, 8'h35);
    rnd_cells = 1; run = 1; rate = 2;
    wait_step(a);
    tick();
    check("gen_one", gen_count, 1);
    wait_step(b);
    check("period_rate2", 8'(b - a), 5);
    tick();
    check("gen_two", gen_count, 2);
    rate = 0;
    for (int i = 0; i < 254; i++) begin
      a = b;
      wait_step(b);
    end
    check("period_rate0", 8'(b - a), 3);
    tick();
    check("gen_wrap", gen_count, 0);
    rnd_cells = 0; cells = 7'h12;
    reseed_pulse();
    auto_en = 1;
    steps_to_load(n);
    check("still_steps", 8'(n), 4);
    check("still_stalled", stalled, 1);
    auto_en = 0; tog = 1;
    reseed_pulse();
    auto_en = 1;
    steps_to_load(n);
    check("p2_steps", 8'(n), 5);
    auto_en = 0;
    for (int i = 0; i < 12; i++) wait_step(a);
    check("p2_stalled_noauto", stalled, 1);
    tog = 0; cells = 7'h00;
    reseed_pulse();
    auto_en = 1;
    steps_to_load(n);
    check("extinct_steps", 8'(n), 1);
    check("extinct_stalled", stalled, 1);
    auto_en = 0; rnd_cells = 1; rate = 3;
    for (int i = 0; i < 60 && !(ph == P_WAIT && m_pre == rate && !m_rprev); i++) tick();
    reseed_req = 1;
    tick();
    check("terminal_reseed_load", load_en, 1);
    check("terminal_reseed_nostep", step_en, 0);
    reseed_req = 0;
    wait_step(a);
    reset = 1;
    model_reset();
    #1;
    check("reset_in_step", step_en, 0);
    repeat (2) tick();
    reset = 0;
    #1;
    check("reload_after_reset", load_en, 1);
    check("reload_seed", load_data, 8'h5A);
    for (int i = 0; i < 4000; i++) begin
      tick();
      step_req = $urandom_range(0, 3) == 0;
      reseed_req = $urandom_range(0, 40) == 0;
      if ($urandom_range(0, 29) == 0) run = ~run;
      if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 39) == 0) rate = 4'($urandom_range(0, 4));
      r = $urandom_range(0, 9);
      rnd_cells = 0;
      cells = (r < 4) ? cells : (r == 4) ? 7'h00 : (r == 5) ? 7'h12 : 7'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1;
        model_reset();
      end else if (reset) reset = 0;
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
